// File: rtl/lamp_pkg.sv
// Shared constants and encodings for the lamp bar observer.
package lamp_pkg;

    localparam int unsigned LAMP_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LVL_W  = $clog2(LAMP_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

// File: rtl/lamp_therm_decode.sv
// Combinational thermometer-code check and fill-level popcount.
module lamp_therm_decode
    import lamp_pkg::*;
(
    input  logic [LAMP_W-1:0] i_lamp,
    output logic              o_valid,
    output logic [LVL_W-1:0]  o_level
);

    logic [LAMP_W-1:0] w_inc;

    // A legal bar is 2^k-1; all-ones wraps to zero and is still legal.
    assign w_inc   = i_lamp + LAMP_W'(1);
    assign o_valid = ((i_lamp & w_inc) == '0);

    always_comb begin
        o_level = '0;
        for (int i = 0; i < LAMP_W; i++) begin
            o_level = o_level + LVL_W'(i_lamp[i]);
        end
    end

endmodule

// File: rtl/lamp_monitor.sv
// Observer for the chaser lamp bar: decodes level/direction, captures
// turnaround points, counts completed runs and flags illegal samples/steps.
module lamp_monitor
    import lamp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LAMP_W-1:0] lamp,
    input  logic              clr_err,
    output logic [LVL_W-1:0]  level,
    output logic [1:0]        dir,
    output logic              turn,
    output logic [LVL_W-1:0]  peak,
    output logic [LVL_W-1:0]  trough,
    output logic              run_done,
    output logic [CNT_W-1:0]  run_cnt,
    output logic              err_pattern,
    output logic              err_step
);

    localparam int unsigned LVX_W = LVL_W + 1;

    logic [LAMP_W-1:0] r_lamp_q;
    state_e            r_state;

    logic              w_valid;
    logic [LVL_W-1:0]  w_new;
    logic [LVX_W-1:0]  w_new_x;
    logic [LVX_W-1:0]  w_lvl_x;
    logic              w_same;
    logic              w_up1;
    logic              w_dn1;
    logic              w_big;
    logic              w_rise;
    logic              w_zero;

    lamp_therm_decode u_decode (
        .i_lamp  (r_lamp_q),
        .o_valid (w_valid),
        .o_level (w_new)
    );

    // Level is also the previous legal level used for the step delta.
    assign w_new_x = {1'b0, w_new};
    assign w_lvl_x = {1'b0, level};
    assign w_same  = (w_new == level);
    assign w_up1   = (w_new_x == w_lvl_x + LVX_W'(1));
    assign w_dn1   = (w_new_x + LVX_W'(1) == w_lvl_x);
    assign w_big   = !w_same && !w_up1 && !w_dn1;
    assign w_rise  = (w_new > level);
    assign w_zero  = (w_new == LVL_W'(0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lamp_q    <= '0;
            r_state     <= ST_IDLE;
            level       <= '0;
            dir         <= DIR_HOLD;
            turn        <= 1'b0;
            peak        <= '0;
            trough      <= '0;
            run_done    <= 1'b0;
            run_cnt     <= '0;
            err_pattern <= 1'b0;
            err_step    <= 1'b0;
        end else begin
            r_lamp_q <= lamp;
            turn     <= 1'b0;
            run_done <= 1'b0;

            // Sticky flags: a new event wins over a simultaneous clear.
            err_pattern <= (err_pattern & ~clr_err) | ~w_valid;
            err_step    <= (err_step & ~clr_err) | (w_valid & w_big);

            if (w_valid) begin
                if (w_same) begin
                    dir <= DIR_HOLD;
                end else if (w_big) begin
                    level <= w_new;
                    dir   <= w_rise ? DIR_UP : DIR_DOWN;
                    if (w_zero) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= w_rise ? ST_UP : ST_DOWN;
                    end
                end else begin
                    level <= w_new;
                    dir   <= w_up1 ? DIR_UP : DIR_DOWN;
                    case (r_state)
                        ST_IDLE: begin
                            if (w_up1) begin
                                r_state <= ST_UP;
                            end
                        end
                        ST_UP: begin
                            if (w_dn1) begin
                                r_state <= ST_DOWN;
                                turn    <= 1'b1;
                                peak    <= level;
                            end
                        end
                        ST_DOWN: begin
                            if (w_up1) begin
                                r_state <= ST_UP;
                                turn    <= 1'b1;
                                trough  <= level;
                            end else if (w_zero) begin
                                r_state  <= ST_IDLE;
                                run_done <= 1'b1;
                                run_cnt  <= run_cnt + CNT_W'(1);
                                trough   <= '0;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
